// File: rtl/decompose_seq_ctrl.sv
// decompose_seq_ctrl: sequential even/odd butterfly decomposition controller.
// Optional busy-cycle counter enabled by DECOMPOSE_SEQ_PERF_EN.
module decompose_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int MAX_N = 32,
    parameter int P     = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [2:0]                                   n_log2,
    input  logic [MAX_N-1:0][WIDTH-1:0]                  in_vector,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [MAX_N-1:0][WIDTH+$clog2(MAX_N)-1:0]    out_vector,
    output logic                                         n_err
`ifdef DECOMPOSE_SEQ_PERF_EN
    ,
    output logic [31:0]                                  busy_cycles
`endif
);

    localparam int LG = $clog2(MAX_N);
    localparam int OW = WIDTH + LG;
    localparam int CW = LG + 1;
    localparam logic [2:0] LG3 = 3'(LG);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [MAX_N-1:0][OW-1:0] bank_t;

    state_t        state;
    state_t        state_nxt;
    logic          sel;
    logic [CW-1:0] len;
    logic [CW-1:0] j;
    logic [CW-1:0] half;
    logic [CW-1:0] n_acc;
    bank_t         bank_a;
    bank_t         bank_b;
    bank_t         src;
    bank_t         dst;
    bank_t         nxt;
    logic          legal;
    logic          accept;
    logic          stage_end;
    logic          last_stage;

    assign legal      = (n_log2 != 3'd0) && (n_log2 <= LG3);
    assign accept     = in_valid && in_ready;
    assign half       = len >> 1;
    assign n_acc      = legal ? (CW'(1) << n_log2) : CW'(2);
    assign src        = sel ? bank_b : bank_a;
    assign dst        = sel ? bank_a : bank_b;
    assign stage_end  = (int'(j) + P) >= int'(half);
    assign last_stage = (half == CW'(2));
    assign out_vector = src;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_acc == CW'(2)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (stage_end && last_stage) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared butterfly array: P pairs of the current stage into the idle bank
    always_comb begin
        nxt = dst;
        for (int m = 0; m < MAX_N; m++) begin
            if (m >= int'(len)) begin
                nxt[m] = src[m];
            end
        end
        for (int k = 0; k < P; k++) begin
            logic [CW-1:0] lo;
            logic [CW-1:0] mir;
            logic [CW-1:0] up;
            logic [OW-1:0] a;
            logic [OW-1:0] b;
            lo  = j + CW'(k);
            mir = len - CW'(1) - lo;
            up  = half + lo;
            a   = src[lo[LG-1:0]];
            b   = src[mir[LG-1:0]];
            if (lo < half) begin
                nxt[lo[LG-1:0]] = a + b;
                nxt[up[LG-1:0]] = a - b;
            end
        end
    end

    // Bank load on acceptance, stage stepping and ping-pong swap during RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_a <= '0;
            bank_b <= '0;
            sel    <= 1'b0;
            len    <= '0;
            j      <= '0;
            n_err  <= 1'b0;
        end else if (accept) begin
            sel   <= 1'b0;
            j     <= '0;
            len   <= n_acc;
            n_err <= !legal;
            for (int m = 0; m < MAX_N; m++) begin
                if (m < int'(n_acc)) begin
                    bank_a[m] <= {{LG{in_vector[m][WIDTH-1]}}, in_vector[m]};
                end else begin
                    bank_a[m] <= '0;
                end
            end
        end else if (state == RUN) begin
            if (sel) begin
                bank_a <= nxt;
            end else begin
                bank_b <= nxt;
            end
            if (stage_end) begin
                sel <= ~sel;
                len <= half;
                j   <= '0;
            end else begin
                j <= j + CW'(P);
            end
        end
    end

`ifdef DECOMPOSE_SEQ_PERF_EN
    // Saturating count of cycles spent in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (state == RUN && busy_cycles != 32'hFFFF_FFFF) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule
